// File: rtl/frame_commit_ctrl.sv
// Frame receive/commit controller: packs an incoming nibble stream into bytes,
// writes them speculatively into a frame buffer and, on the checksum engine's
// verdict, either commits the frame (advances commit_ptr) or rolls it back.
//
// state  | meaning
// IDLE   | checksum engine held in reset, waiting for an axiiv rising edge
// RECV   | nibbles arriving, bytes written at wr_ptr
// WAIT   | stream ended on a byte boundary, waiting for the engine's verdict
// COMMIT | frame accepted, commit_ptr/frame_len updated
// DROP   | frame rejected, wr_ptr rolled back to commit_ptr
module frame_commit_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [3:0]        axiid,
    input  logic              ck_done,
    input  logic              ck_kill,
    output logic              ck_rst,
    output logic              ck_axiiv,
    output logic [3:0]        ck_axiid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] commit_ptr,
    output logic              frame_good,
    output logic              frame_bad,
    output logic [ADDR_W:0]   frame_len
);

    typedef enum logic [2:0] {IDLE, RECV, WAIT, COMMIT, DROP} state_t;

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic              axiiv_prev;
    logic              parity;
    logic [3:0]        nib_lo;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   byte_cnt;
    logic [TMR_W-1:0]  timer;
    logic              rise;
    logic              full;
    logic              go_drop;
    logic              go_commit;

    assign rise = axiiv & ~axiiv_prev;
    // Buffer already holds 2^ADDR_W bytes of this frame; one more would wrap onto it.
    assign full = byte_cnt[ADDR_W];

    // Decide whether this cycle ends the frame, so the pulse lines up with the state change.
    always_comb begin
        go_drop   = 1'b0;
        go_commit = 1'b0;
        case (state)
            RECV: go_drop = parity & (~axiiv | full);
            WAIT: begin
                if (ck_kill)
                    go_drop = 1'b1;
                else if (ck_done)
                    go_commit = 1'b1;
                else if (rise || timer == '0)
                    go_drop = 1'b1;
            end
            default: ;
        endcase
    end

    // Main FSM with registered outputs; the edge detector keeps sampling during reset
    // so a still-high axiiv is not mistaken for a new frame afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            axiiv_prev <= axiiv;
            parity     <= 1'b0;
            nib_lo     <= '0;
            wr_ptr     <= '0;
            byte_cnt   <= '0;
            timer      <= '0;
            ck_rst     <= 1'b1;
            ck_axiiv   <= 1'b0;
            ck_axiid   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            commit_ptr <= '0;
            frame_good <= 1'b0;
            frame_bad  <= 1'b0;
            frame_len  <= '0;
        end else begin
            axiiv_prev <= axiiv;
            wr_en      <= 1'b0;
            ck_axiiv   <= 1'b0;
            ck_axiid   <= '0;
            frame_good <= go_commit;
            frame_bad  <= go_drop;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= RECV;
                        ck_rst   <= 1'b0;
                        ck_axiiv <= 1'b1;
                        ck_axiid <= axiid;
                        nib_lo   <= axiid;
                        parity   <= 1'b1;
                        byte_cnt <= '0;
                    end
                end
                RECV: begin
                    if (go_drop) begin
                        state  <= DROP;
                        wr_ptr <= commit_ptr;
                    end else if (!axiiv) begin
                        state <= WAIT;
                        timer <= TMR_W'(TIMEOUT - 1);
                    end else begin
                        ck_axiiv <= 1'b1;
                        ck_axiid <= axiid;
                        parity   <= ~parity;
                        if (!parity) begin
                            nib_lo <= axiid;
                        end else begin
                            wr_en    <= 1'b1;
                            wr_addr  <= wr_ptr;
                            wr_data  <= {axiid, nib_lo};
                            wr_ptr   <= wr_ptr + 1'b1;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (go_commit) begin
                        state      <= COMMIT;
                        commit_ptr <= wr_ptr;
                        frame_len  <= byte_cnt;
                    end else if (go_drop) begin
                        state  <= DROP;
                        wr_ptr <= commit_ptr;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                COMMIT, DROP: begin
                    state  <= IDLE;
                    ck_rst <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    ck_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_commit_ctrl.md
FRAME_COMMIT_CTRL -- requirements
Module: frame_commit_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, frame-buffer byte-address width; capacity is 2^ADDR_W bytes.
REQ-002 Parameter TIMEOUT, default 16, maximum number of cycles in WAIT for a checker verdict.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 axiiv  in  1  incoming nibble-stream valid.
REQ-006 axiid  in  4  incoming nibble, low nibble of each byte first.
REQ-007 ck_done  in  1  checksum engine result valid.
REQ-008 ck_kill  in  1  checksum engine mismatch flag.
REQ-009 ck_rst  out  1  active-high reset to the checksum engine.
REQ-010 ck_axiiv  out  1  registered copy of axiiv, forwarded to the engine.
REQ-011 ck_axiid  out  4  registered copy of axiid, forwarded to the engine.
REQ-012 wr_en  out  1  frame-buffer byte write strobe.
REQ-013 wr_addr  out  ADDR_W  frame-buffer write address.
REQ-014 wr_data  out  8  packed byte {second nibble, first nibble}.
REQ-015 commit_ptr  out  ADDR_W  address one past the last committed byte.
REQ-016 frame_good  out  1  one-cycle pulse when a frame is committed.
REQ-017 frame_bad  out  1  one-cycle pulse when a frame is dropped.
REQ-018 frame_len  out  ADDR_W+1  byte count of the last committed frame.

Function
REQ-019 The FSM SHALL have states IDLE, RECV, WAIT, COMMIT and DROP.
REQ-020 In IDLE, ck_rst SHALL be 1; in every other state it SHALL be 0, registered.
REQ-021 IDLE->RECV SHALL occur only on an axiiv rising edge (axiiv=1 and previous-cycle axiiv=0); a held-high axiiv SHALL NOT start a frame.
REQ-022 ck_axiiv and ck_axiid SHALL follow axiiv and axiid with exactly 1 cycle latency in RECV, and SHALL be 0 in all other states.
REQ-023 In RECV, the nibble parity SHALL toggle on each valid nibble; on each second nibble, wr_en=1 (registered, 1 cycle after that nibble), with wr_data={nibble2,nibble1} and wr_addr=wr_ptr; wr_ptr SHALL then increment modulo 2^ADDR_W.
REQ-024 The byte count SHALL reset to 0 at frame start and increment with every write.
REQ-025 If a write would make the byte count exceed 2^ADDR_W, that write SHALL be suppressed and the FSM SHALL go to DROP.
REQ-026 When axiiv falls in RECV with even parity, the FSM SHALL go to WAIT; with odd parity (dangling nibble), it SHALL go to DROP.
REQ-027 ck_done and ck_kill SHALL be ignored outside WAIT.
REQ-028 In WAIT: ck_kill=1 -> DROP (kill takes priority over done); ck_done=1 with ck_kill=0 -> COMMIT; axiiv rising -> DROP; TIMEOUT cycles elapsed with no verdict -> DROP.
REQ-029 COMMIT (1 cycle) SHALL set commit_ptr<=wr_ptr, frame_len<=byte count, frame_good=1, then go to IDLE.
REQ-030 DROP (1 cycle) SHALL roll back wr_ptr<=commit_ptr, set frame_bad=1, leave commit_ptr and frame_len unchanged, then go to IDLE.
REQ-031 frame_good and frame_bad SHALL never both be 1, and each SHALL be high for exactly 1 cycle per frame.
REQ-032 A frame aborted by DROP SHALL leave later frames unaffected; the next frame SHALL start writing at commit_ptr.

Reset
REQ-033 While rst=0 at a clock edge: state=IDLE, ck_rst=1, wr_ptr=commit_ptr=0, frame_len=0, and all other outputs 0.
REQ-034 A reset asserted mid-frame SHALL abort the frame without any frame_good or frame_bad pulse.
REQ-035 After reset releases, REQ-021 SHALL apply: a still-high axiiv SHALL NOT start a frame.

Verification
REQ-036 60 nibbles of 0x5 then A,6,C,0,D,A,C,3; ck_done=1, ck_kill=0 two cycles after axiiv falls -> 34 writes at addresses 0..33, the first wr_data=0x55 and the last =0x3C; frame_good pulses once; commit_ptr=34, frame_len=34.
REQ-037 Same frame with ck_kill=1 and ck_done=1 -> frame_bad pulses once; commit_ptr=0; the next frame's first write is at wr_addr=0.
REQ-038 7-nibble frame -> 3 writes, then frame_bad; commit_ptr unchanged.
REQ-039 Even-length frame with no verdict, TIMEOUT=16 -> frame_bad exactly 16 cycles after WAIT entry.
REQ-040 rst=0 for 1 cycle mid-RECV while axiiv stays high -> ck_rst=1, no pulse, pointers 0; no frame starts until axiiv goes 0 then 1.
REQ-041 ADDR_W=4, 40-nibble frame -> 16 writes, the 17th suppressed, frame_bad pulses, commit_ptr=0.
